// File: rtl/fft_reorder_if.sv
// fft_reorder_if: sample stream into and out of the FFT reorder stage.
// master drives din_* and observes dout_*; slave is the reorder block.
interface fft_reorder_if #(
  parameter int width = 16,
  parameter int NALL  = 9
);
  logic                    din_en;
  logic [NALL-1:0]         din_cnt;
  logic signed [width-1:0] din_re;
  logic signed [width-1:0] din_im;
  logic                    dout_en;
  logic [NALL-1:0]         dout_cnt;
  logic signed [width-1:0] dout_re;
  logic signed [width-1:0] dout_im;
  logic                    dout_sof;
  logic                    overrun;

  modport master (
    output din_en, din_cnt, din_re, din_im,
    input  dout_en, dout_cnt, dout_re, dout_im,
    input  dout_sof, overrun
  );

  modport slave (
    input  din_en, din_cnt, din_re, din_im,
    output dout_en, dout_cnt, dout_re, dout_im,
    output dout_sof, overrun
  );
endinterface

// File: rtl/fft_reorder.sv
// fft_reorder: bit-reversed FFT frames in, natural-order bursts out.
// Optional macro FFT_REORDER_FFTSHIFT_EN emits the burst DC-centred.
module fft_reorder #(
  parameter int width = 16,
  parameter int NALL  = 9
) (
  input  logic         clk,
  input  logic         areset,
  fft_reorder_if.slave io
);

  localparam int DEPTH = 1 << NALL;
  localparam logic [NALL-1:0] LAST = '1;

`ifdef FFT_REORDER_FFTSHIFT_EN
  localparam logic [NALL-1:0] RMASK = LAST ^ (LAST >> 1);
`else
  localparam logic [NALL-1:0] RMASK = '0;
`endif

  // first address of every burst; marks dout_sof
  localparam logic [NALL-1:0] FIRST = RMASK;

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  state_t          state;
  logic            wbank;
  logic            rbank;
  logic [NALL-1:0] rcnt;

  logic [2*width-1:0] mem [2*DEPTH];
  logic [2*width-1:0] rd_q;
  logic               rd_v;
  logic [NALL-1:0]    rd_cnt;

  logic            frame_done;
  logic            rd_last;
  logic [NALL-1:0] raddr;
  logic [NALL-1:0] waddr;

  function automatic logic [NALL-1:0] bitrev(
    input logic [NALL-1:0] a
  );
    logic [NALL-1:0] r;
    r = '0;
    for (int i = 0; i < NALL; i++) begin
      r[NALL-1-i] = a[i];
    end
    return r;
  endfunction

  assign frame_done = io.din_en && (io.din_cnt == LAST);
  assign rd_last    = (state == READ) && (rcnt == LAST);
  assign raddr      = rcnt ^ RMASK;
  assign waddr      = bitrev(io.din_cnt);

  // ping-pong RAM write port: sample lands at its true bin index
  always_ff @(posedge clk) begin
    if (!areset && io.din_en) begin
      mem[{wbank, waddr}] <= {io.din_re, io.din_im};
    end
  end

  // registered RAM read port, only active while bursting
  always_ff @(posedge clk) begin
    if (state == READ) begin
      rd_q <= mem[{rbank, raddr}];
    end
  end

  // bank swap / burst FSM and registered output stage
  always_ff @(posedge clk) begin
    if (areset) begin
      state       <= IDLE;
      wbank       <= 1'b0;
      rbank       <= 1'b0;
      rcnt        <= '0;
      rd_v        <= 1'b0;
      rd_cnt      <= '0;
      io.dout_en  <= 1'b0;
      io.dout_cnt <= '0;
      io.dout_re  <= '0;
      io.dout_im  <= '0;
      io.dout_sof <= 1'b0;
      io.overrun  <= 1'b0;
    end else begin
      rd_v <= (state == READ);
      if (state == READ) begin
        rd_cnt <= raddr;
        rcnt   <= rcnt + 1'b1;
      end
      if (rd_last) begin
        state <= IDLE;
      end

      // a frame landing on the final read edge chains seamlessly
      if (frame_done) begin
        if (state == IDLE || rd_last) begin
          rbank <= wbank;
          wbank <= ~wbank;
          state <= READ;
          rcnt  <= '0;
        end else begin
          io.overrun <= 1'b1;
        end
      end

      io.dout_en  <= rd_v;
      io.dout_sof <= rd_v && (rd_cnt == FIRST);
      if (rd_v) begin
        io.dout_cnt <= rd_cnt;
        io.dout_re  <= rd_q[2*width-1:width];
        io.dout_im  <= rd_q[width-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: random/directed frames vs a bin-level model.
// Expected bursts are queued at stimulus time, checked by a monitor.
module tb_fft_reorder;

  localparam int W = 16;
  localparam int N = 3;
  localparam int D = 1 << N;
  localparam logic [N-1:0] ALL1 = '1;

  logic clk = 1'b0;
  logic areset = 1'b1;

  always #5 clk = ~clk;

  fft_reorder_if #(.width(W), .NALL(N)) io();

  fft_reorder #(.width(W), .NALL(N)) dut (
    .clk    (clk),
    .areset (areset),
    .io     (io)
  );

  typedef struct {
    int           at;
    logic [N-1:0] cnt;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         sof;
  } exp_t;

  exp_t sb[$];

  int edge_n = 0;
  int n_chk = 0;
  int n_fail = 0;
  int busy_until = 0;
  int last_t = 0;
  int ovr_at = 0;
  bit exp_ovr = 1'b0;

  logic [W-1:0] f_re [D];
  logic [W-1:0] f_im [D];

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [N-1:0] brev(input logic [N-1:0] a);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[N-1-i] = a[i];
    return r;
  endfunction

  // k-th bin of an output burst
  function automatic logic [N-1:0] out_bin(input int k);
    logic [N-1:0] b;
    b = k[N-1:0];
`ifdef FFT_REORDER_FFTSHIFT_EN
    b[N-1] = ~b[N-1];
`endif
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at edge %0d",
               name, got, exp, edge_n);
    end
  endtask

  // frame completes at edge t: accepted if the previous burst's last
  // read is at or before t, otherwise dropped with sticky overrun
  task automatic complete(input int t);
    exp_t e;
    if (t >= busy_until) begin
      for (int k = 0; k < D; k++) begin
        e.at  = t + 2 + k;
        e.cnt = out_bin(k);
        e.re  = f_re[out_bin(k)];
        e.im  = f_im[out_bin(k)];
        e.sof = (k == 0);
        sb.push_back(e);
      end
      busy_until = t + D;
      last_t = t;
    end else if (!exp_ovr) begin
      exp_ovr = 1'b1;
      ovr_at = t;
    end
  endtask

  task automatic drive(input bit en, input logic [N-1:0] c,
                       input logic [W-1:0] re, input logic [W-1:0] im);
    @(negedge clk);
    io.din_en  = en;
    io.din_cnt = c;
    io.din_re  = re;
    io.din_im  = im;
    if (en) begin
      f_re[brev(c)] = re;
      f_im[brev(c)] = im;
      if (c == ALL1) complete(edge_n + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, '0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    areset = 1'b1;
    io.din_en = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      sb.delete();
      exp_ovr = 1'b0;
      busy_until = 0;
    end
    @(negedge clk);
    check("rst_en", {31'b0, io.dout_en}, 32'd0);
    check("rst_cnt", {29'b0, io.dout_cnt}, 32'd0);
    check("rst_re", {16'b0, io.dout_re}, 32'd0);
    check("rst_im", {16'b0, io.dout_im}, 32'd0);
    check("rst_sof", {31'b0, io.dout_sof}, 32'd0);
    check("rst_ovr", {31'b0, io.overrun}, 32'd0);
    areset = 1'b0;
  endtask

  // scoreboard monitor: every output cycle must match the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!areset) begin
      if (io.dout_en) begin
        if (sb.size() == 0) begin
          check("unexpected_out", {31'b0, io.dout_en}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_edge", edge_n, e.at);
          check("out_cnt", {29'b0, io.dout_cnt}, {29'b0, e.cnt});
          check("out_re", {16'b0, io.dout_re}, {16'b0, e.re});
          check("out_im", {16'b0, io.dout_im}, {16'b0, e.im});
          check("out_sof", {31'b0, io.dout_sof}, {31'b0, e.sof});
        end
      end else if (sb.size() > 0 && sb[0].at <= edge_n) begin
        e = sb.pop_front();
        check("missing_out", {31'b0, io.dout_en}, 32'd1);
      end
      check("overrun", {31'b0, io.overrun},
            {31'b0, (exp_ovr && edge_n >= ovr_at)});
    end
  end

  initial begin
    logic [W-1:0] v;
    int guard;
    int gp;
    io.din_en  = 1'b0;
    io.din_cnt = '0;
    io.din_re  = '0;
    io.din_im  = '0;

    do_reset(2);
    idle(2);

    // basic: re = bin, im = -bin
    for (int c = 0; c < D; c++) begin
      v = {{(W-N){1'b0}}, brev(c[N-1:0])};
      drive(1'b1, c[N-1:0], v, -v);
    end
    idle(12);

    // gapped input, same frame
    for (int c = 0; c < D; c++) begin
      v = {{(W-N){1'b0}}, brev(c[N-1:0])};
      drive(1'b1, c[N-1:0], v, -v);
      idle(1);
    end
    idle(12);

    // three contiguous back-to-back frames
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < D; c++) begin
        v = W'(f * 1000 + int'(brev(c[N-1:0])));
        drive(1'b1, c[N-1:0], v, ~v);
      end
    end
    idle(14);

    // overrun: frame completes, next cycle jumps to the last count
    for (int c = 0; c < D; c++) begin
      drive(1'b1, c[N-1:0], W'($urandom), W'($urandom));
    end
    drive(1'b1, ALL1, 16'h7777, 16'h8888);
    idle(14);

    // random frames, random gap density (some contiguous)
    for (int f = 0; f < 8; f++) begin
      gp = $urandom_range(0, 3);
      for (int c = 0; c < D; c++) begin
        while (gp != 0 && $urandom_range(0, 3) < gp) idle(1);
        drive(1'b1, c[N-1:0], W'($urandom), W'($urandom));
      end
    end
    idle(14);

    // reset while the 4th output bin is on the bus
    for (int c = 0; c < D; c++) begin
      drive(1'b1, c[N-1:0], W'($urandom), W'($urandom));
    end
    idle(1);
    while (edge_n < last_t + 4) idle(1);
    do_reset(1);
    idle(12);
    for (int c = 0; c < D; c++) begin
      drive(1'b1, c[N-1:0], W'($urandom), W'($urandom));
    end
    idle(1);

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      idle(1);
      guard++;
    end
    check("drain_timeout", sb.size(), 32'd0);
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
